param_sync_fifo: RTL and testbench
==================================

Name: param_sync_fifo

Overview:
Single-clock, parametrised FIFO buffer with independent write and read enables. Width, depth and almost-full/almost-empty thresholds are set by parameters. It adds the following over the fixed 8x8 single-control FIFO:
- full use of all DEPTH entries
- simultaneous read and write in one cycle
- an occupancy count
- sticky overflow and underflow error flags
- synchronous flush
It sits between a producer and a consumer stage as a general-purpose rate-matching buffer.

Parameters:
DWIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of pointers/count; memory contents untouched
wr_en  input  1  write request
din  input  DWIDTH  write data
rd_en  input  1  read request
dout  output  DWIDTH  read data, registered
dout_valid  output  1  one-cycle pulse: dout updated by an accepted read
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async, rst=1) clears wptr, rptr, count, dout, dout_valid, overflow and underflow to 0. Flags settle to empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? 1 : 0). Memory is not reset.
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB is a wrap bit. Addresses are the low bits, so wrap-around at DEPTH is natural. Count is held as a register, not derived from the pointers.
- Write accepted (wr_acc) = wr_en & !full, evaluated against pre-edge state. On accept: mem[wptr] <= din; wptr increments.
- Read accepted (rd_acc) = rd_en & !empty, evaluated against pre-edge state. On accept: dout <= mem[rptr]; rptr increments; dout_valid <= 1 for one cycle. With no accept, dout holds its value and dout_valid <= 0.
- Read latency: data appears on dout on the edge that accepts rd_en, so it is visible in the following cycle.
- Simultaneous wr_acc & rd_acc: both are performed and count is unchanged.
- When full with wr_en & rd_en: the read is accepted; the write is rejected and overflow sets.
- When empty with wr_en & rd_en: the write is accepted; the read is rejected and underflow sets. There is no fall-through: the written word is readable from the next cycle.
- Count: +1 on wr_acc only, -1 on rd_acc only, unchanged otherwise. It never exceeds DEPTH and never goes below 0.
- full, empty, almost_full and almost_empty are combinational decodes of the count register. They are glitch-free relative to clk.
- overflow sets on wr_en & full; underflow sets on rd_en & empty. Both are sticky until clr_err or rst. If a set and clr_err occur in the same cycle, the set wins.
- flush (synchronous): wptr, rptr and count go to 0 and dout_valid goes to 0. dout holds. Any wr_en/rd_en in the same cycle is ignored and does not set error flags. Error flags are unaffected by flush.
- Reset mid-operation: state clears immediately (async), independent of clk. The first accepted write after rst deasserts lands at address 0.

Test Plan:
- DWIDTH=8, DEPTH=8: rst, then write 0x01..0x08 over 8 cycles -> count=8, full=1, almost_full=1. A 9th write of 0x09 -> rejected, overflow=1, count stays 8.
- Continuing from full: read 8 times -> dout sequence 0x01..0x08, one cycle after each rd_en with dout_valid pulsing. Then empty=1 and count=0. A 9th read -> underflow=1 and dout holds 0x08.
- Wrap-around: write 5, read 5, then write 0xA0..0xA7 and read 8 -> data returns in order across the pointer wrap, and full asserts exactly at count 8.
- Simultaneous: at count=4, assert wr_en+rd_en for 10 cycles -> count stays 4 and data order is preserved. At full, wr_en+rd_en -> count=7, overflow=1. At empty, wr_en+rd_en -> count=1, underflow=1, dout_valid=0.
- Thresholds AF=6, AE=2: fill 0->8 -> almost_empty deasserts at count 3 and almost_full asserts at count 6.
- At count=5, assert flush with wr_en=1 -> count=0, empty=1, no error set. Then assert rst asynchronously mid-burst -> all outputs at reset values before the next clk edge. clr_err clears the sticky flags.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with independent write/read enables, count, error flags and flush.
// Latency: a write is readable from the cycle after it is accepted; read data is registered (dout valid the cycle after rd_en).
// Backpressure: writes are refused while full (overflow sticks) and reads are refused while empty (underflow sticks).
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   flush               synchronous clear of pointers and count; memory and error flags untouched
//   wr_en, din          write request and data
//   rd_en               read request
//   dout, dout_valid    registered read data and one-cycle "dout updated" pulse
//   full, empty         count == DEPTH / count == 0
//   almost_full/_empty  count >= AF_THRESH / count <= AE_THRESH
//   count               occupancy 0..DEPTH
//   overflow/underflow  sticky error flags, cleared by clr_err or rst
module param_sync_fifo #(
  parameter int DWIDTH    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     rd_en,
  output logic [DWIDTH-1:0]        dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]     wptr_q, wptr_d;
  logic [CW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic wr_acc;
  logic rd_acc;

  // Flags decode the count register only, so they change cleanly on clk.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // Flush wins over both requests: nothing is accepted in a flush cycle.
  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q & ~clr_err;
    underflow_d  = underflow_q & ~clr_err;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + ONE_C;
      end
      if (rd_acc) begin
        rptr_d       = rptr_q + ONE_C;
        dout_d       = mem_q[rptr_q[AW-1:0]];
        dout_valid_d = 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      // A fresh error beats a same-cycle clear.
      if (wr_en & full) begin
        overflow_d = 1'b1;
      end
      if (rd_en & empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage has no reset; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  // The count register and the wrap-bit pointer distance must always agree.
  a_count_matches_ptrs : assert property (@(posedge clk) disable iff (rst)
    count_q == CW'(wptr_q - rptr_q));

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid, full, empty, almost_full, almost_empty;
  logic [3:0]    count;
  logic          overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a plain queue plus the observable registers.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_dv = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  param_sync_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f, input logic c);
    bit was_full, was_empty;
    wr_en = w; din = d; rd_en = r; flush = f; clr_err = c;
    @(posedge clk);
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (f) begin
      mq.delete();
      m_dv = 1'b0;
    end else begin
      if (r && !was_empty) begin m_dout = mq.pop_front(); m_dv = 1'b1; end
      else m_dv = 1'b0;
      if (w && !was_full) mq.push_back(d);
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got, exp;
    got = {dout, dout_valid, count};
    exp = {8'h00, 1'b0, 4'd0};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL reset_regs: got %h expected %h", got, exp); end
    got = {8'h00, full, empty, almost_full, almost_empty, overflow};
    exp = {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL reset_flags: got %h expected %h", got, exp); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (count !== 4'(mq.size())) begin n_err++; $display("FAIL fill_count: got %0d expected %0d", count, mq.size()); end
    end
    n_cmp++; if ({full, almost_full} !== 2'b11) begin n_err++; $display("FAIL fill_full: got %b expected 11", {full, almost_full}); end
    step(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({overflow, count} !== {1'b1, 4'd8}) begin n_err++; $display("FAIL fill_overflow: got ovf=%b cnt=%0d expected ovf=1 cnt=8", overflow, count); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (dout !== DW'(i) || dout !== m_dout || dout_valid !== 1'b1) begin
        n_err++; $display("FAIL drain_data: got %h/%b expected %h/1", dout, dout_valid, DW'(i));
      end
    end
    n_cmp++; if ({empty, count} !== {1'b1, 4'd0}) begin n_err++; $display("FAIL drain_empty: got e=%b cnt=%0d expected e=1 cnt=0", empty, count); end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({underflow, dout_valid, dout} !== {1'b1, 1'b0, 8'h08}) begin
      n_err++; $display("FAIL drain_underflow: got unf=%b dv=%b dout=%h expected 1 0 08", underflow, dout_valid, dout);
    end
  endtask

  task automatic test_clr_err();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if ({overflow, underflow} !== {m_ovf, m_unf} || m_ovf || m_unf) begin
      n_err++; $display("FAIL clr_err: got %b%b expected 00", overflow, underflow);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h50 + DW'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'hA0 + DW'(i), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (full !== (mq.size() == DEPTH) || count !== 4'(mq.size())) begin
        n_err++; $display("FAIL wrap_full: got full=%b cnt=%0d expected cnt=%0d", full, count, mq.size());
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (dout !== 8'hA0 + DW'(i) || dout !== m_dout) begin
        n_err++; $display("FAIL wrap_data: got %h expected %h", dout, 8'hA0 + DW'(i));
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
      n_cmp++; if (count !== 4'd4 || dout !== m_dout || dout_valid !== 1'b1) begin
        n_err++; $display("FAIL simul_steady: got cnt=%0d dout=%h dv=%b expected cnt=4 dout=%h dv=1", count, dout, dout_valid, m_dout);
      end
    end
    for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({count, overflow} !== {4'd7, 1'b1} || dout !== m_dout) begin
      n_err++; $display("FAIL simul_full: got cnt=%0d ovf=%b dout=%h expected cnt=7 ovf=1 dout=%h", count, overflow, dout, m_dout);
    end
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({count, underflow, dout_valid} !== {4'd1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL simul_empty: got cnt=%0d unf=%b dv=%b expected 1 1 0", count, underflow, dout_valid);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (dout !== 8'h77 || {overflow, underflow} !== 2'b00) begin
      n_err++; $display("FAIL simul_readback: got dout=%h err=%b%b expected 77 00", dout, overflow, underflow);
    end
  endtask

  task automatic test_thresholds();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (almost_empty !== (mq.size() <= AE) || almost_full !== (mq.size() >= AF)) begin
        n_err++; $display("FAIL thresh: at cnt=%0d got ae=%b af=%b expected ae=%b af=%b",
                          mq.size(), almost_empty, almost_full, mq.size() <= AE, mq.size() >= AF);
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL flush_pre: got cnt=%0d expected 5", count); end
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    n_cmp++; if ({count, empty, overflow, underflow, dout_valid} !== {4'd0, 1'b1, 3'b000} || dout !== m_dout) begin
      n_err++; $display("FAIL flush: got cnt=%0d e=%b ovf=%b unf=%b dv=%b dout=%h expected 0 1 0 0 0 %h",
                        count, empty, overflow, underflow, dout_valid, dout, m_dout);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h6B, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h7C, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    wr_en = 1'b1; din = 8'h33;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({count, empty, full, dout_valid, overflow, underflow} !== {4'd0, 1'b1, 4'b0000} || dout !== 8'h00) begin
      n_err++; $display("FAIL async_reset: got cnt=%0d e=%b f=%b dv=%b ovf=%b unf=%b dout=%h expected 0 1 0 0 0 0 00",
                        count, empty, full, dout_valid, overflow, underflow, dout);
    end
    model_reset();
    @(negedge clk);
    wr_en = 1'b0; rst = 1'b0;
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (dout !== 8'h3C || count !== 4'd0 || dout_valid !== 1'b1) begin
      n_err++; $display("FAIL post_reset_rw: got dout=%h cnt=%0d dv=%b expected 3c 0 1", dout, count, dout_valid);
    end
  endtask

  task automatic test_random();
    logic [12:0] got, exp;
    bit w, r, f, c;
    for (int i = 0; i < 400; i++) begin
      // Alternate fill-biased and drain-biased phases so full and empty are both visited.
      if (((i / 40) % 2) == 0) begin w = ($urandom_range(0, 9) < 7); r = ($urandom_range(0, 9) < 3); end
      else                     begin w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 7); end
      f = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 19) == 0);
      step(w, DW'($urandom), r, f, c);
      exp = {4'(mq.size()), mq.size() == DEPTH, mq.size() == 0, mq.size() >= AF, mq.size() <= AE,
             m_ovf, m_unf, m_dv, 2'b00};
      got = {count, full, empty, almost_full, almost_empty, overflow, underflow, dout_valid, 2'b00};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rand_status[%0d]: got %b expected %b", i, got, exp); end
      n_cmp++; if (dout !== m_dout) begin n_err++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, dout, m_dout); end
    end
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_fill();
    test_drain();
    test_clr_err();
    test_wrap();
    test_simultaneous();
    test_thresholds();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
